// File: rtl/brent_kung_adder.sv
// 32-bit Brent-Kung parallel-prefix adder with carry-in/out and registered sum.
// Optional macro BKA_INPUT_REG_EN adds an input register stage (2-cycle latency).
module brent_kung_adder (
  input  logic clk,
  input  logic rst,
  input  logic A_1,  A_2,  A_3,  A_4,  A_5,  A_6,  A_7,  A_8,
  input  logic A_9,  A_10, A_11, A_12, A_13, A_14, A_15, A_16,
  input  logic A_17, A_18, A_19, A_20, A_21, A_22, A_23, A_24,
  input  logic A_25, A_26, A_27, A_28, A_29, A_30, A_31, A_32,
  input  logic B_1,  B_2,  B_3,  B_4,  B_5,  B_6,  B_7,  B_8,
  input  logic B_9,  B_10, B_11, B_12, B_13, B_14, B_15, B_16,
  input  logic B_17, B_18, B_19, B_20, B_21, B_22, B_23, B_24,
  input  logic B_25, B_26, B_27, B_28, B_29, B_30, B_31, B_32,
  input  logic C_0,
  output logic S_1,  S_2,  S_3,  S_4,  S_5,  S_6,  S_7,  S_8,
  output logic S_9,  S_10, S_11, S_12, S_13, S_14, S_15, S_16,
  output logic S_17, S_18, S_19, S_20, S_21, S_22, S_23, S_24,
  output logic S_25, S_26, S_27, S_28, S_29, S_30, S_31, S_32,
  output logic C_out
);

  // Brent-Kung prefix tree: 31 up-sweep nodes then 26 down-sweep nodes.
  // Returns the group generate of bits [k:0] at position k, i.e. carry out of bit k.
  function automatic logic [31:0] bk_carry(input logic [31:0] g, input logic [31:0] p);
    logic [31:0] gg;
    logic [31:0] pp;
    gg = g;
    pp = p;
    for (int l = 0; l < 5; l++) begin
      for (int k = (2 << l) - 1; k < 32; k += (2 << l)) begin
        gg[k] = gg[k] | (pp[k] & gg[k - (1 << l)]);
        pp[k] = pp[k] & pp[k - (1 << l)];
      end
    end
    for (int l = 3; l >= 0; l--) begin
      for (int k = 3 * (1 << l) - 1; k < 32; k += (2 << l)) begin
        gg[k] = gg[k] | (pp[k] & gg[k - (1 << l)]);
        pp[k] = pp[k] & pp[k - (1 << l)];
      end
    end
    return gg;
  endfunction

  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [31:0] op_a_s;
  logic [31:0] op_b_s;
  logic        op_c0_s;
  logic [31:0] gen_s;
  logic [31:0] prop_s;
  logic [31:0] gfold_s;
  logic [31:0] gc_s;
  logic [31:0] sum_s;
  logic [31:0] sum_r;
  logic        cout_r;

  assign a_s = {A_32, A_31, A_30, A_29, A_28, A_27, A_26, A_25,
                A_24, A_23, A_22, A_21, A_20, A_19, A_18, A_17,
                A_16, A_15, A_14, A_13, A_12, A_11, A_10, A_9,
                A_8,  A_7,  A_6,  A_5,  A_4,  A_3,  A_2,  A_1};
  assign b_s = {B_32, B_31, B_30, B_29, B_28, B_27, B_26, B_25,
                B_24, B_23, B_22, B_21, B_20, B_19, B_18, B_17,
                B_16, B_15, B_14, B_13, B_12, B_11, B_10, B_9,
                B_8,  B_7,  B_6,  B_5,  B_4,  B_3,  B_2,  B_1};

`ifdef BKA_INPUT_REG_EN
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        c0_r;

  // Input capture stage ahead of the prefix tree.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r  <= 32'd0;
      b_r  <= 32'd0;
      c0_r <= 1'b0;
    end else begin
      a_r  <= a_s;
      b_r  <= b_s;
      c0_r <= C_0;
    end
  end

  assign op_a_s  = a_r;
  assign op_b_s  = b_r;
  assign op_c0_s = c0_r;
`else
  assign op_a_s  = a_s;
  assign op_b_s  = b_s;
  assign op_c0_s = C_0;
`endif

  assign gen_s  = op_a_s & op_b_s;
  assign prop_s = op_a_s ^ op_b_s;
  // Carry-in folded into bit 0 so the tree needs no extra column.
  assign gfold_s = {gen_s[31:1], gen_s[0] | (prop_s[0] & op_c0_s)};
  assign gc_s    = bk_carry(gfold_s, prop_s);
  assign sum_s   = prop_s ^ {gc_s[30:0], op_c0_s};

  // Output register: reset wins over the computed result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r  <= 32'd0;
      cout_r <= 1'b0;
    end else begin
      sum_r  <= sum_s;
      cout_r <= gc_s[31];
    end
  end

  assign {S_32, S_31, S_30, S_29, S_28, S_27, S_26, S_25,
          S_24, S_23, S_22, S_21, S_20, S_19, S_18, S_17,
          S_16, S_15, S_14, S_13, S_12, S_11, S_10, S_9,
          S_8,  S_7,  S_6,  S_5,  S_4,  S_3,  S_2,  S_1} = sum_r;
  assign C_out = cout_r;

endmodule

// File: tb/tb_brent_kung_adder.sv
// Self-checking bench for brent_kung_adder: directed table, reset sequences and
// random back-to-back stream checked against a 33-bit arithmetic delay-line model.
module tb_brent_kung_adder;

`ifdef BKA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        c0;
  wire  [31:0] s;
  wire         c_out;

  int unsigned errors;
  int unsigned checks;
  logic [32:0] pipe [0:LAT-1];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c0;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs [0:6];

  brent_kung_adder dut (
    .clk(clk), .rst(rst),
    .A_1(a[0]),   .A_2(a[1]),   .A_3(a[2]),   .A_4(a[3]),   .A_5(a[4]),   .A_6(a[5]),   .A_7(a[6]),   .A_8(a[7]),
    .A_9(a[8]),   .A_10(a[9]),  .A_11(a[10]), .A_12(a[11]), .A_13(a[12]), .A_14(a[13]), .A_15(a[14]), .A_16(a[15]),
    .A_17(a[16]), .A_18(a[17]), .A_19(a[18]), .A_20(a[19]), .A_21(a[20]), .A_22(a[21]), .A_23(a[22]), .A_24(a[23]),
    .A_25(a[24]), .A_26(a[25]), .A_27(a[26]), .A_28(a[27]), .A_29(a[28]), .A_30(a[29]), .A_31(a[30]), .A_32(a[31]),
    .B_1(b[0]),   .B_2(b[1]),   .B_3(b[2]),   .B_4(b[3]),   .B_5(b[4]),   .B_6(b[5]),   .B_7(b[6]),   .B_8(b[7]),
    .B_9(b[8]),   .B_10(b[9]),  .B_11(b[10]), .B_12(b[11]), .B_13(b[12]), .B_14(b[13]), .B_15(b[14]), .B_16(b[15]),
    .B_17(b[16]), .B_18(b[17]), .B_19(b[18]), .B_20(b[19]), .B_21(b[20]), .B_22(b[21]), .B_23(b[22]), .B_24(b[23]),
    .B_25(b[24]), .B_26(b[25]), .B_27(b[26]), .B_28(b[27]), .B_29(b[28]), .B_30(b[29]), .B_31(b[30]), .B_32(b[31]),
    .C_0(c0),
    .S_1(s[0]),   .S_2(s[1]),   .S_3(s[2]),   .S_4(s[3]),   .S_5(s[4]),   .S_6(s[5]),   .S_7(s[6]),   .S_8(s[7]),
    .S_9(s[8]),   .S_10(s[9]),  .S_11(s[10]), .S_12(s[11]), .S_13(s[12]), .S_14(s[13]), .S_15(s[14]), .S_16(s[15]),
    .S_17(s[16]), .S_18(s[17]), .S_19(s[18]), .S_20(s[19]), .S_21(s[20]), .S_22(s[21]), .S_23(s[22]), .S_24(s[23]),
    .S_25(s[24]), .S_26(s[25]), .S_27(s[26]), .S_28(s[27]), .S_29(s[28]), .S_30(s[29]), .S_31(s[30]), .S_32(s[31]),
    .C_out(c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] golden(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {32'd0, c};
  endfunction

  task automatic check(input string name, input logic [32:0] exp);
    checks++;
    if ({c_out, s} !== exp) begin
      errors++;
      $display("FAIL %s: got C_out=%0b S=%08h, expected C_out=%0b S=%08h",
               name, c_out, s, exp[32], exp[31:0]);
    end
  endtask

  // One clock edge: advance the delay-line model with what the DUT sampled, then compare.
  task automatic step(input string name);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] = 33'd0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = golden(a, b, c0);
    end
    #1;
    check(name, pipe[LAT-1]);
  endtask

  initial begin
    logic [32:0] hold_exp;
    errors = 0;
    checks = 0;
    for (int i = 0; i < LAT; i++) pipe[i] = 33'd0;

    vecs[0] = '{32'h88B388B3, 32'h88B188B1, 1'b0, 33'h1_11651164};
    vecs[1] = '{32'h00000085, 32'h0000008C, 1'b0, 33'h0_00000111};
    vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF};
    vecs[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 33'h0_80000000};
    vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 33'h0_FFFFFFFF};
    vecs[6] = '{32'h80000000, 32'h80000000, 1'b1, 33'h1_00000001};

    // Reset with nonzero inputs: outputs must clear.
    rst = 1'b1; a = 32'hDEADBEEF; b = 32'h12345678; c0 = 1'b1;
    step("reset0");
    step("reset1");
    check("reset_zero", 33'd0);
    rst = 1'b0;

    // Directed table: hold each vector for LAT edges, compare against table constant.
    for (int v = 0; v < 7; v++) begin
      a = vecs[v].a; b = vecs[v].b; c0 = vecs[v].c0;
      for (int e = 0; e < LAT; e++) step("table_model");
      check($sformatf("table%0d", v), vecs[v].exp);
    end

    // Random back-to-back stream.
    for (int n = 0; n < 10000; n++) begin
      a = $urandom; b = $urandom; c0 = 1'($urandom_range(1, 0));
      step("random");
    end

    // One-edge reset during a nonzero stream.
    a = 32'hF0F0F0F0; b = 32'h0F0F0F10; c0 = 1'b1;
    step("pre_rst_stream");
    a = 32'h13572468; b = 32'h2468ACE0; c0 = 1'b0;
    rst = 1'b1;
    step("mid_rst_model");
    check("mid_rst_zero", 33'd0);
    rst = 1'b0;
    hold_exp = 33'h0_37BFD148;
    if (LAT == 2) begin
      step("post_rst_fill");
      check("post_rst_fill_zero", 33'd0);
    end
    step("post_rst_model");
    check("post_rst_sum", hold_exp);

    // Full ripple right after reset release.
    a = 32'hFFFFFFFF; b = 32'h00000000; c0 = 1'b1;
    for (int e = 0; e < LAT; e++) step("ripple_model");
    check("ripple", 33'h1_00000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/brent_kung_adder.md
Name: brent_kung_adder

Overview:
32-bit parallel-prefix adder using a Brent-Kung carry tree, with carry-in and carry-out. Operands, carry-in and sum are individual 1-bit ports, indexed 1..32 with bit 1 as the LSB. The result is registered, so the block drops straight into a pipelined datapath as a single-cycle-latency adder stage.

Parameters:
None. Width is fixed at 32 bits, and the port list is explicit per bit.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
A_1 .. A_32  input  1 each  operand A; A_1 is the LSB, A_32 the MSB
B_1 .. B_32  input  1 each  operand B; B_1 is the LSB, B_32 the MSB
C_0  input  1  carry-in (weight 2^0)
S_1 .. S_32  output  1 each  registered sum bits; S_1 is the LSB
C_out  output  1  registered carry-out (weight 2^32)

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Function: {C_out, S_32..S_1} = A + B + C_0, a full 33-bit result, unsigned. No overflow flag.
- Bit-level generate/propagate:
  - g_i = A_i & B_i and p_i = A_i ^ B_i, for i = 1..32.
  - Carry-in is folded into bit 1: G_1 = g_1 | (p_1 & C_0).
- Prefix operator: (G,P) o (G',P') = (G | P&G', P&P').
- Brent-Kung tree structure:
  - Up-sweep: 5 levels, span 1, 2, 4, 8, 16.
  - Down-sweep: 4 levels, filling the remaining odd positions.
  - Result: group generate Gc_i for every bit 1..32. Gc_i is the carry out of bit i.
  - No Kogge-Stone-style full fan-out; total prefix nodes = 2*32 - 2 - log2(32) = 57.
- Sum and carry:
  - S_1 = p_1 ^ C_0.
  - S_i = p_i ^ Gc_(i-1), for i = 2..32.
  - C_out = Gc_32.
- Timing:
  - Combinational result is captured into S_1..S_32 and C_out on each rising clk edge.
  - Latency is 1 cycle: inputs valid before edge N produce outputs after edge N.
- Throughput: one new operand set per cycle. No handshake and no enable.
- Reset:
  - rst high at a rising edge clears S_1..S_32 and C_out to 0 on that edge. Reset overrides any computed result.
  - Outputs are undefined before the first reset.
  - Deasserting rst: the first valid result appears one edge after rst is low with stable inputs.
  - Reset mid-stream discards the in-flight result; no state survives.
- Boundaries:
  - Full carry ripple, e.g. all-ones + 0 + C_0=1, must propagate through the tree in one cycle: S=0, C_out=1.
  - The MSB carry must be correct for all inputs.
- Combinational inputs have no X-propagation requirements beyond standard simulation semantics.

Optional Feature:
Macro BKA_INPUT_REG_EN.
- Defined: A, B and C_0 are registered on clk before the prefix tree, so latency becomes 2 cycles. The input registers also clear to 0 on rst. Outputs after reset therefore read 0 for two cycles, then results follow with 2-cycle latency.
- Undefined: no input registers, and latency is 1 cycle as above.
- Function and reset values are otherwise identical in both builds.

Test Plan:
- A=0x88B388B3, B=0x88B188B1, C_0=0 -> after 1 cycle S=0x11651164, C_out=1.
- A=0x00000085, B=0x0000008C, C_0=0 -> S=0x00000111 (273), C_out=0.
- A=0xFFFFFFFF, B=0x00000000, C_0=1 -> S=0x00000000, C_out=1. Checks the full-length carry path.
- A=0xFFFFFFFF, B=0xFFFFFFFF, C_0=1 -> S=0xFFFFFFFF, C_out=1. Then A=0x7FFFFFFF, B=0x00000001, C_0=0 -> S=0x80000000, C_out=0.
- Back-to-back new operands every cycle, with 10k random vectors including random C_0 -> each output matches the 33-bit golden A+B+C_0 exactly 1 cycle later (2 cycles with BKA_INPUT_REG_EN).
- Assert rst for one edge while nonzero results are streaming -> S=0 and C_out=0 on that edge. With rst low, the next edge shows the sum of the current inputs.
